// File: rtl/des_pkg.sv
// Shared DES constants: widths, permutation tables, S-boxes, key rotation schedules and FSM states.
// Tables use DES bit numbering (1 = MSB); the helpers map that numbering onto [W-1:0] vectors.
package des_pkg;

  localparam int BLK_W  = 64;
  localparam int KEY_W  = 56;
  localparam int SUB_W  = 48;
  localparam int HALF_W = 32;
  localparam int CD_W   = 28;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int E_T [48] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};

  // Each S-box is indexed by {row, col} = {b1 b6, b2 b3 b4 b5}.
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Decrypt shifts right (round 0 uses K16 unrotated); encrypt shifts left.
  localparam int ROT_DEC [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int ROT_ENC [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  function automatic logic [BLK_W-1:0] ip_perm(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] fp_perm(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] pc1_perm(input logic [BLK_W-1:0] x);
    logic [KEY_W-1:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [SUB_W-1:0] pc2_perm(input logic [KEY_W-1:0] x);
    logic [SUB_W-1:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [SUB_W-1:0] e_perm(input logic [HALF_W-1:0] x);
    logic [SUB_W-1:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [HALF_W-1:0] p_perm(input logic [HALF_W-1:0] x);
    logic [HALF_W-1:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] c, input int n);
    case (n)
      1:       return {c[0], c[27:1]};
      2:       return {c[1:0], c[27:2]};
      default: return c;
    endcase
  endfunction

  function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] c, input int n);
    case (n)
      1:       return {c[26:0], c[27]};
      2:       return {c[25:0], c[27:26]};
      default: return c;
    endcase
  endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R,K): E expansion, subkey XOR, eight S-boxes, P permutation.
module des_f
  import des_pkg::*;
(
  input  logic [HALF_W-1:0] i_r,
  input  logic [SUB_W-1:0]  i_k,
  output logic [HALF_W-1:0] o_f
);

  logic [SUB_W-1:0]  w_x;
  logic [HALF_W-1:0] w_s;

  assign w_x = e_perm(i_r) ^ i_k;

  // S-box j consumes DES bits 6j+1..6j+6 and drives f bits 4j+1..4j+4.
  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [5:0] w_six;
    assign w_six = w_x[42-6*j +: 6];
    assign w_s[28-4*j +: 4] = 4'(SBOX[j][{w_six[5], w_six[0], w_six[4:1]}]);
  end

  assign o_f = p_perm(w_s);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryptor, one Feistel round per clock, subkeys K16..K1 generated by right rotation.
// Optional DES_ENC_MODE_EN adds an enc_mode input selecting left-rotating encrypt key schedule.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] ct_in,
  input  logic [BLK_W-1:0] key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] pt_out,
  output logic             busy
`ifdef DES_ENC_MODE_EN
  , input  logic           enc_mode
`endif
);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [HALF_W-1:0] r_l, r_r;
  logic [CD_W-1:0]   r_c, r_d;
  logic [BLK_W-1:0]  r_pt;
  logic              r_out_valid, r_in_ready, r_busy;

  logic [BLK_W-1:0]  w_ip;
  logic [KEY_W-1:0]  w_pc1;
  logic [SUB_W-1:0]  w_k;
  logic [HALF_W-1:0] w_f, w_r_new;
  logic [3:0]        w_nidx;
  logic [CD_W-1:0]   w_c_init, w_d_init, w_c_nxt, w_d_nxt;

  assign w_ip    = ip_perm(ct_in);
  assign w_pc1   = pc1_perm(key_in);
  assign w_k     = pc2_perm({r_c, r_d});
  assign w_r_new = r_l ^ w_f;
  // Wraps to 0 on the last round; the rotated C/D are unused after that.
  assign w_nidx  = r_cnt + 4'd1;

`ifdef DES_ENC_MODE_EN
  logic r_mode;
  assign w_c_init = enc_mode ? rotl28(w_pc1[55:28], ROT_ENC[0]) : w_pc1[55:28];
  assign w_d_init = enc_mode ? rotl28(w_pc1[27:0],  ROT_ENC[0]) : w_pc1[27:0];
  assign w_c_nxt  = r_mode ? rotl28(r_c, ROT_ENC[w_nidx]) : rotr28(r_c, ROT_DEC[w_nidx]);
  assign w_d_nxt  = r_mode ? rotl28(r_d, ROT_ENC[w_nidx]) : rotr28(r_d, ROT_DEC[w_nidx]);
`else
  assign w_c_init = w_pc1[55:28];
  assign w_d_init = w_pc1[27:0];
  assign w_c_nxt  = rotr28(r_c, ROT_DEC[w_nidx]);
  assign w_d_nxt  = rotr28(r_d, ROT_DEC[w_nidx]);
`endif

  des_f u_f (
    .i_r (r_r),
    .i_k (w_k),
    .o_f (w_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_l         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_pt        <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
`ifdef DES_ENC_MODE_EN
      r_mode      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_l        <= w_ip[63:32];
            r_r        <= w_ip[31:0];
            r_c        <= w_c_init;
            r_d        <= w_d_init;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef DES_ENC_MODE_EN
            r_mode     <= enc_mode;
`endif
            r_state    <= ROUND;
          end
        end
        ROUND: begin
          r_l   <= r_r;
          r_r   <= w_r_new;
          r_c   <= w_c_nxt;
          r_d   <= w_d_nxt;
          r_cnt <= w_nidx;
          if (r_cnt == 4'd15) begin
            // Final swap undone: preoutput is {R16, L16}.
            r_pt        <= fp_perm({w_r_new, r_r});
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign pt_out    = r_pt;
  assign busy      = r_busy;

endmodule
